// File: rtl/io_port_if.sv
// Bus bundle between the CPU/UART side and io_port: CPU memory port, UART rx/tx
// byte handshakes and the program-stop level.
interface io_port_if;
  logic        rdy_in;
  logic [17:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  io_din;
  logic        io_stall;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        prog_stop;

  modport master (
    output rdy_in, mem_a, mem_wr, mem_dout, rx_valid, rx_data, tx_ready,
    input  io_din, io_stall, rx_ready, tx_valid, tx_data, prog_stop
  );

  modport slave (
    input  rdy_in, mem_a, mem_wr, mem_dout, rx_valid, rx_data, tx_ready,
    output io_din, io_stall, rx_ready, tx_valid, tx_data, prog_stop
  );
endinterface

// File: rtl/io_port.sv
// Memory-mapped IO block: console TX/RX FIFOs, program-stop register and a
// free-running cycle counter readable byte by byte through a snapshot latch.
module io_port (
  input  logic      clk_in,
  input  logic      rst_in,
  io_port_if.slave  bus
);

  localparam logic [17:0] ADDR_CONSOLE = 18'h30000;
  localparam logic [17:0] ADDR_TIMER0  = 18'h30004;
  localparam logic [17:0] ADDR_TIMER1  = 18'h30005;
  localparam logic [17:0] ADDR_TIMER2  = 18'h30006;
  localparam logic [17:0] ADDR_TIMER3  = 18'h30007;

  logic [7:0]  r_tx_mem [8];
  logic [2:0]  r_tx_rd;
  logic [2:0]  r_tx_wr;
  logic [3:0]  r_tx_cnt;
  logic [7:0]  r_rx_mem [4];
  logic [1:0]  r_rx_rd;
  logic [1:0]  r_rx_wr;
  logic [2:0]  r_rx_cnt;
  logic [31:0] r_cycle;
  logic [31:0] r_latch;
  logic [7:0]  r_io_din;
  logic        r_prog_stop;

  logic        w_io;
  logic        w_io_wr;
  logic        w_io_rd;
  logic        w_tx_req;
  logic        w_tx_full;
  logic        w_tx_pop;
  logic        w_tx_stall;
  logic        w_tx_push;
  logic [7:0]  w_tx_push_data;
  logic        w_rx_ready;
  logic        w_rx_push;
  logic        w_rx_req;
  logic        w_rx_stall;
  logic        w_rx_pop;

  assign w_io    = bus.rdy_in && (bus.mem_a[17:16] == 2'b11);
  assign w_io_wr = w_io && bus.mem_wr;
  assign w_io_rd = w_io && !bus.mem_wr;

  // A write of 0x00 to the console is a no-op; the stop register always enqueues a 0x00 marker.
  assign w_tx_req = w_io_wr && !r_prog_stop &&
                    (((bus.mem_a == ADDR_CONSOLE) && (bus.mem_dout != 8'h00)) ||
                     (bus.mem_a == ADDR_TIMER0));
  assign w_tx_full      = (r_tx_cnt == 4'd8);
  assign w_tx_pop       = (r_tx_cnt != 4'd0) && bus.tx_ready;
  assign w_tx_stall     = w_tx_req && w_tx_full && !w_tx_pop;
  assign w_tx_push      = w_tx_req && !w_tx_stall;
  assign w_tx_push_data = (bus.mem_a == ADDR_TIMER0) ? 8'h00 : bus.mem_dout;

  assign w_rx_ready = (r_rx_cnt < 3'd4);
  assign w_rx_push  = bus.rx_valid && w_rx_ready;
  assign w_rx_req   = w_io_rd && (bus.mem_a == ADDR_CONSOLE);
  assign w_rx_stall = w_rx_req && (r_rx_cnt == 3'd0);
  assign w_rx_pop   = w_rx_req && !w_rx_stall;

  assign bus.io_stall  = w_tx_stall || w_rx_stall;
  assign bus.tx_valid  = (r_tx_cnt != 4'd0);
  assign bus.tx_data   = r_tx_mem[r_tx_rd];
  assign bus.rx_ready  = w_rx_ready;
  assign bus.io_din    = r_io_din;
  assign bus.prog_stop = r_prog_stop;

  // Storage arrays carry no reset; validity is tracked by the counts alone.
  always_ff @(posedge clk_in) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= w_tx_push_data;
    if (w_rx_push) r_rx_mem[r_rx_wr] <= bus.rx_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_tx_rd  <= 3'd0;
      r_tx_wr  <= 3'd0;
      r_tx_cnt <= 4'd0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + 3'd1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + 3'd1;
      if (w_tx_push && !w_tx_pop)
        r_tx_cnt <= r_tx_cnt + 4'd1;
      else if (!w_tx_push && w_tx_pop)
        r_tx_cnt <= r_tx_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rx_rd  <= 2'd0;
      r_rx_wr  <= 2'd0;
      r_rx_cnt <= 3'd0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + 2'd1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 2'd1;
      if (w_rx_push && !w_rx_pop)
        r_rx_cnt <= r_rx_cnt + 3'd1;
      else if (!w_rx_push && w_rx_pop)
        r_rx_cnt <= r_rx_cnt - 3'd1;
    end
  end

  // The counter runs regardless of rdy_in; the latch only changes on a byte-0 read.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cycle     <= 32'd0;
      r_latch     <= 32'd0;
      r_io_din    <= 8'h00;
      r_prog_stop <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_tx_push && (bus.mem_a == ADDR_TIMER0))
        r_prog_stop <= 1'b1;
      if (w_io_rd) begin
        case (bus.mem_a)
          ADDR_CONSOLE: if (w_rx_pop) r_io_din <= r_rx_mem[r_rx_rd];
          ADDR_TIMER0: begin
            r_latch  <= r_cycle;
            r_io_din <= r_cycle[7:0];
          end
          ADDR_TIMER1: r_io_din <= r_latch[15:8];
          ADDR_TIMER2: r_io_din <= r_latch[23:16];
          ADDR_TIMER3: r_io_din <= r_latch[31:24];
          default:     r_io_din <= 8'h00;
        endcase
      end
    end
  end

endmodule

// File: doc/io_port.md
IO_PORT -- requirements
Module: io_port

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low: clk_in  in  1  system clock, rising edge.
REQ-002 SHALL have rst_in  in  1  asynchronous active-low reset.
REQ-003 SHALL have rdy_in  in  1  CPU ready; bus access ignored while low.
REQ-004 SHALL have mem_a  in  18  CPU address bus (bits 17:0).
REQ-005 SHALL have mem_wr  in  1  CPU write strobe (1 = write).
REQ-006 SHALL have mem_dout  in  8  CPU write data.
REQ-007 SHALL have io_din  out  8  read data returned to CPU.
REQ-008 SHALL have io_stall  out  1  CPU must hold its current bus request.
REQ-009 SHALL have rx_valid  in  1  UART receive byte valid.
REQ-010 SHALL have rx_data  in  8  UART receive byte.
REQ-011 SHALL have rx_ready  out  1  block can accept an rx byte.
REQ-012 SHALL have tx_valid  out  1  transmit byte valid.
REQ-013 SHALL have tx_data  out  8  transmit byte.
REQ-014 SHALL have tx_ready  in  1  UART consumes tx byte this cycle.
REQ-015 SHALL have prog_stop  out  1  level, set once program stop is requested.

Function
REQ-016 SHALL decode an IO access when rdy_in=1 and mem_a[17:16]=2'b11; all other addresses are ignored and leave state unchanged.
REQ-017 SHALL contain an 8-entry x 8-bit TX FIFO with 3-bit wrapping read and write pointers and a 4-bit count.
REQ-018 SHALL contain a 4-entry x 8-bit RX FIFO with 2-bit wrapping pointers and a 3-bit count.
REQ-019 SHALL drive rx_ready = (RX count < 4); a byte SHALL be pushed on any cycle with rx_valid && rx_ready.
REQ-020 SHALL drive tx_valid = (TX count != 0) and tx_data = TX head; the head SHALL be popped on any cycle with tx_valid && tx_ready.
REQ-021 SHALL, on a write to 0x30000 with nonzero data and TX not full, push mem_dout into TX; a write of 0x00 SHALL be ignored.
REQ-022 SHALL, on a write to 0x30000 with TX full, assert io_stall combinationally in the same cycle and perform no push.
REQ-023 SHALL, on a write to 0x30004, push 0x00 into TX (stall if full, as in REQ-022) and then set prog_stop; once prog_stop is set, all later TX writes SHALL be ignored.
REQ-024 SHALL, on a read of 0x30000, pop the RX head and present it on io_din in the next cycle (one-cycle read latency); if RX is empty, io_stall SHALL assert and no pop occurs.
REQ-025 SHALL maintain a 32-bit free-running cycle counter, incremented every clock after reset regardless of rdy_in, and wrapping 0xFFFFFFFF -> 0.
REQ-026 SHALL, on a read of 0x30004, snapshot the counter into a 32-bit latch and return byte 0 (bits 7:0) next cycle.
REQ-027 SHALL return latch bytes 1, 2 and 3 on reads of 0x30005, 0x30006 and 0x30007 respectively, without re-snapshotting.
REQ-028 SHALL return 0x00 next cycle on a read of any other IO address.
REQ-029 SHALL, when push and pop coincide on the same FIFO, perform both: count is unchanged and both pointers advance; this also applies when the TX FIFO is full and tx_ready=1, so a CPU write then proceeds without stall.
REQ-030 SHALL hold io_din at its last value when no IO read occurred in the prior cycle.
REQ-031 SHALL make io_stall purely combinational from the current request and FIFO state, with no registered state.

Reset
REQ-032 SHALL, while rst_in=0, asynchronously clear both FIFOs' pointers and counts, the counter, the latch, io_din (0x00) and prog_stop (0); outputs then read tx_valid=0, rx_ready=1, io_stall=0.
REQ-033 SHALL, when reset is asserted mid-operation, discard FIFO contents and abort any in-flight read; the first counter value after release SHALL be 0.

Verification
REQ-034 Write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=0 -> TX count=2, tx_data=0x41; then tx_ready=1 for 2 cycles -> 0x41 then 0x42, tx_valid=0.
REQ-035 Nine nonzero writes to 0x30000 with tx_ready=0 -> ninth write sees io_stall=1; one pop with simultaneous write -> count stays 8, io_stall=0.
REQ-036 Read 0x30000 with RX empty -> io_stall=1; rx_valid pulse with rx_data=0x5A -> the next read returns io_din=0x5A one cycle later, RX count=0.
REQ-037 Read 0x30004 at counter value 0x00012345, then 0x30005..0x30007 -> bytes 0x45, 0x23, 0x01, 0x00 in order despite counter advancing.
REQ-038 Write 0x30004 -> tx_data=0x00 enqueued, prog_stop=1; a subsequent write of 0x33 to 0x30000 -> TX count unchanged.
REQ-039 Assert rst_in=0 with TX count=3 and RX count=2 -> all counts 0, prog_stop=0, io_din=0x00 immediately, without waiting for a clock edge.
